// File: rtl/io_device_decoder.sv
// Registered device-select stage behind the I/O bridge: decodes adr[19:16] into a one-hot
// slot request and turns unmapped or silent devices into an all-ones ack plus an error report.
module io_device_decoder #(
  parameter int NDEV    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 m_cyc_i,
  input  logic                 m_stb_i,
  output logic                 m_ack_o,
  input  logic                 m_we_i,
  input  logic [3:0]           m_sel_i,
  input  logic [31:0]          m_adr_i,
  input  logic [31:0]          m_dat_i,
  output logic [31:0]          m_dat_o,
  output logic [NDEV-1:0]      dev_cyc_o,
  output logic [NDEV-1:0]      dev_stb_o,
  input  logic [NDEV-1:0]      dev_ack_i,
  output logic                 dev_we_o,
  output logic [3:0]           dev_sel_o,
  output logic [31:0]          dev_adr_o,
  output logic [31:0]          dev_dat_o,
  input  logic [32*NDEV-1:0]   dev_dat_i,
  output logic                 err_o,
  output logic [31:0]          err_adr_o,
  output logic                 err_tmo_o
);

  // state  | meaning
  // IDLE   | waiting for a new request from the bridge
  // ACCESS | one slot selected, waiting for its ack, an abort or the timeout
  // RESP   | holding ack/data until the bridge drops stb or cyc

  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NDEV-1:0] slot_q, slot_d;
  logic            ack_d;
  logic [31:0]     mdat_d;
  logic            we_d;
  logic [3:0]      bsel_d;
  logic [31:0]     adr_d;
  logic [31:0]     wdat_d;
  logic            err_d;
  logic [31:0]     err_adr_d;
  logic            err_tmo_d;

  logic [3:0]      req_slot;
  logic            req_valid;
  logic            req_mapped;
  logic            ack_hit;
  logic [NDEV-1:0] req_onehot;
  logic [31:0]     sel_rdata;

  assign req_slot   = m_adr_i[19:16];
  assign req_valid  = m_cyc_i & m_stb_i & ~m_ack_o;
  // Slot 2 is the FTA window and is never forwarded, whatever NDEV is.
  assign req_mapped = (req_slot != 4'd2) && (int'(req_slot) < NDEV);
  assign ack_hit    = |(dev_ack_i & slot_q);

  assign dev_cyc_o  = slot_q;
  assign dev_stb_o  = slot_q;

  always_comb begin
    req_onehot = '0;
    for (int k = 0; k < NDEV; k++) begin
      if (int'(req_slot) == k) req_onehot[k] = 1'b1;
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NDEV; k++) begin
      sel_rdata = sel_rdata | (dev_dat_i[32*k +: 32] & {32{slot_q[k]}});
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    ack_d     = m_ack_o;
    mdat_d    = m_dat_o;
    we_d      = dev_we_o;
    bsel_d    = dev_sel_o;
    adr_d     = dev_adr_o;
    wdat_d    = dev_dat_o;
    err_d     = 1'b0;
    err_adr_d = err_adr_o;
    err_tmo_d = err_tmo_o;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d   = m_we_i;
          bsel_d = m_sel_i;
          adr_d  = m_adr_i;
          wdat_d = m_dat_i;
          if (req_mapped) begin
            slot_d  = req_onehot;
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            mdat_d    = '1;
            ack_d     = 1'b1;
            err_d     = 1'b1;
            err_adr_d = m_adr_i;
            err_tmo_d = 1'b0;
            state_d   = RESP;
          end
        end
      end
      ACCESS: begin
        // A device ack wins over a simultaneous cyc drop so completed writes are reported.
        if (ack_hit) begin
          mdat_d  = dev_we_o ? 32'h0 : sel_rdata;
          slot_d  = '0;
          ack_d   = 1'b1;
          state_d = RESP;
        end else if (!m_cyc_i) begin
          slot_d  = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          slot_d    = '0;
          mdat_d    = '1;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          err_adr_d = dev_adr_o;
          err_tmo_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (!m_stb_i || !m_cyc_i) begin
          ack_d   = 1'b0;
          mdat_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      slot_q    <= '0;
      m_ack_o   <= 1'b0;
      m_dat_o   <= '0;
      dev_we_o  <= 1'b0;
      dev_sel_o <= '0;
      dev_adr_o <= '0;
      dev_dat_o <= '0;
      err_o     <= 1'b0;
      err_adr_o <= '0;
      err_tmo_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      m_ack_o   <= ack_d;
      m_dat_o   <= mdat_d;
      dev_we_o  <= we_d;
      dev_sel_o <= bsel_d;
      dev_adr_o <= adr_d;
      dev_dat_o <= wdat_d;
      err_o     <= err_d;
      err_adr_o <= err_adr_d;
      err_tmo_o <= err_tmo_d;
    end
  end

endmodule

// File: tb/tb_io_device_decoder.sv
// Bench for io_device_decoder: fixed vector table, hand-written corner sequences and
// random transactions checked against a transaction-level reference model.
module tb_io_device_decoder;
  localparam int NDEV    = 8;
  localparam int TIMEOUT = 4;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 m_cyc_i = 1'b0;
  logic                 m_stb_i = 1'b0;
  logic                 m_ack_o;
  logic                 m_we_i = 1'b0;
  logic [3:0]           m_sel_i = '0;
  logic [31:0]          m_adr_i = '0;
  logic [31:0]          m_dat_i = '0;
  logic [31:0]          m_dat_o;
  logic [NDEV-1:0]      dev_cyc_o;
  logic [NDEV-1:0]      dev_stb_o;
  logic [NDEV-1:0]      dev_ack_i = '0;
  logic                 dev_we_o;
  logic [3:0]           dev_sel_o;
  logic [31:0]          dev_adr_o;
  logic [31:0]          dev_dat_o;
  logic [32*NDEV-1:0]   dev_dat_i = '0;
  logic                 err_o;
  logic [31:0]          err_adr_o;
  logic                 err_tmo_o;

  always #5 clk = ~clk;

  io_device_decoder #(.NDEV(NDEV), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_ack_o(m_ack_o), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .dev_cyc_o(dev_cyc_o), .dev_stb_o(dev_stb_o), .dev_ack_i(dev_ack_i),
    .dev_we_o(dev_we_o), .dev_sel_o(dev_sel_o), .dev_adr_o(dev_adr_o),
    .dev_dat_o(dev_dat_o), .dev_dat_i(dev_dat_i),
    .err_o(err_o), .err_adr_o(err_adr_o), .err_tmo_o(err_tmo_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ack_k: the device acks in its ack_k-th strobe cycle (0 = first); beyond TIMEOUT it never does.
  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    int          ack_k;
    logic [31:0] rdat;
    bit          noise;
    int          hold;
    int          exp_lat;
    logic [31:0] exp_dat;
    bit          exp_err;
    bit          exp_tmo;
  } vec_t;

  vec_t vecs[9];

  // Transaction-level model: latency counts edges from the one that samples the request.
  task automatic ref_model(input logic [31:0] adr, input logic we, input int ack_k,
                           input logic [31:0] rdat, output int lat, output logic [31:0] dat,
                           output bit err, output bit tmo);
    int slot;
    slot = int'(adr[19:16]);
    if (slot >= NDEV || slot == 2) begin
      lat = 1; dat = 32'hFFFF_FFFF; err = 1'b1; tmo = 1'b0;
    end else if (ack_k <= TIMEOUT) begin
      lat = 2 + ack_k; dat = we ? 32'h0 : rdat; err = 1'b0; tmo = 1'b0;
    end else begin
      lat = 2 + TIMEOUT; dat = 32'hFFFF_FFFF; err = 1'b1; tmo = 1'b1;
    end
  endtask

  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdat, input int ack_k, input logic [31:0] rdat,
                         input bit noise, input int hold, input int exp_lat,
                         input logic [31:0] exp_dat, input bit exp_err, input bit exp_tmo);
    int slot, edges, stb_cnt, cyc_cnt, err_cnt, exp_cyc;
    bit done;
    logic [NDEV-1:0] onehot, mask;
    slot = int'(adr[19:16]);
    onehot = '0;
    if (slot < NDEV && slot != 2) onehot[slot] = 1'b1;
    mask = noise ? ~onehot : '0;
    if (exp_err && !exp_tmo) exp_cyc = 0;
    else if (exp_tmo) exp_cyc = TIMEOUT + 1;
    else exp_cyc = exp_lat - 1;
    for (int s = 0; s < NDEV; s++) dev_dat_i[32*s +: 32] = $urandom;
    if (onehot != '0) dev_dat_i[32*slot +: 32] = rdat;

    @(negedge clk);
    m_adr_i = adr; m_we_i = we; m_sel_i = sel; m_dat_i = wdat;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; dev_ack_i = mask;
    edges = 0; stb_cnt = 0; cyc_cnt = 0; err_cnt = 0; done = 1'b0;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (err_o) err_cnt++;
      if (dev_cyc_o != '0) begin
        cyc_cnt++;
        chk("cyc_onehot", 32'(dev_cyc_o), 32'(onehot));
      end
      if (m_ack_o) begin
        done = 1'b1;
      end else if (|dev_stb_o) begin
        if (stb_cnt == 0) begin
          chk("bus_we", 32'(dev_we_o), 32'(we));
          chk("bus_sel", 32'(dev_sel_o), 32'(sel));
          chk("bus_dat", dev_dat_o, wdat);
        end
        dev_ack_i = (stb_cnt == ack_k) ? (mask | onehot) : mask;
        stb_cnt++;
      end else begin
        dev_ack_i = mask;
      end
    end
    chk("latency", 32'(edges), 32'(exp_lat));
    chk("rdata", m_dat_o, exp_dat);
    chk("bus_adr", dev_adr_o, adr);
    dev_ack_i = '0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (err_o) err_cnt++;
      chk("hold_ack", 32'(m_ack_o), 32'd1);
      chk("hold_dat", m_dat_o, exp_dat);
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (err_o) err_cnt++;
    chk("release_ack", 32'(m_ack_o), 32'd0);
    chk("release_dat", m_dat_o, 32'd0);
    chk("err_pulses", 32'(err_cnt), 32'(exp_err));
    chk("cyc_cycles", 32'(cyc_cnt), 32'(exp_cyc));
    if (exp_err) begin
      chk("err_adr", err_adr_o, adr);
      chk("err_tmo", 32'(err_tmo_o), 32'(exp_tmo));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int lat;
    logic [31:0] dat;
    bit err, tmo;
    logic [31:0] adr;

    vecs[0] = '{32'hFD01_0004, 1'b0, 4'hF, 32'h0,         0, 32'h1234_5678, 1'b0, 0, 2, 32'h1234_5678, 1'b0, 1'b0};
    vecs[1] = '{32'hFD05_0000, 1'b1, 4'hF, 32'hA5A5_A5A5, 1, 32'h1111_2222, 1'b0, 0, 3, 32'h0000_0000, 1'b0, 1'b0};
    vecs[2] = '{32'hFD0A_0000, 1'b0, 4'hF, 32'h0,         0, 32'h0,         1'b0, 0, 1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{32'hFD02_0000, 1'b0, 4'h3, 32'h0,         0, 32'h0,         1'b0, 1, 1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[4] = '{32'hFD03_0040, 1'b0, 4'hF, 32'h0,        99, 32'h0,         1'b0, 0, 6, 32'hFFFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'hFD07_0100, 1'b0, 4'hF, 32'h0,         4, 32'hCAFE_F00D, 1'b1, 2, 6, 32'hCAFE_F00D, 1'b0, 1'b0};
    vecs[6] = '{32'hFD00_0008, 1'b0, 4'h1, 32'h0,         2, 32'h0BAD_BEEF, 1'b1, 0, 4, 32'h0BAD_BEEF, 1'b0, 1'b0};
    vecs[7] = '{32'hFD0F_0000, 1'b1, 4'hC, 32'h1234_0000, 0, 32'h0,         1'b0, 0, 1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[8] = '{32'hFD06_FFFC, 1'b0, 4'hF, 32'h0,        99, 32'h0,         1'b1, 1, 6, 32'hFFFF_FFFF, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(m_ack_o), 32'd0);
    chk("rst_mdat", m_dat_o, 32'd0);
    chk("rst_cyc", 32'(dev_cyc_o), 32'd0);
    chk("rst_stb", 32'(dev_stb_o), 32'd0);
    chk("rst_bus", {dev_adr_o | dev_dat_o | {27'd0, dev_sel_o, dev_we_o}}, 32'd0);
    chk("rst_err", {29'd0, err_o, err_tmo_o, |err_adr_o}, 32'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].wdat, vecs[i].ack_k, vecs[i].rdat,
              vecs[i].noise, vecs[i].hold, vecs[i].exp_lat, vecs[i].exp_dat,
              vecs[i].exp_err, vecs[i].exp_tmo);
    end

    // Abort: slot 0 selected for two cycles, then cyc dropped without an ack.
    @(negedge clk);
    m_adr_i = 32'hFD00_0010; m_we_i = 1'b0; m_sel_i = 4'hF; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_cyc1", 32'(dev_cyc_o), 32'h01);
    @(posedge clk); @(negedge clk);
    chk("abort_cyc2", 32'(dev_cyc_o), 32'h01);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_cleared", 32'(dev_cyc_o), 32'd0);
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (m_ack_o || err_o) bad++;
      @(posedge clk); @(negedge clk);
    end
    chk("abort_no_ack", 32'(bad), 32'd0);
    run_txn(32'hFD01_0020, 1'b0, 4'hF, 32'h0, 1, 32'h7777_0001, 1'b0, 0, 3, 32'h7777_0001, 1'b0, 1'b0);

    // Device ack on the same edge as cyc dropping still completes the access.
    @(negedge clk);
    m_adr_i = 32'hFD04_0000; m_we_i = 1'b0; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    dev_dat_i[32*4 +: 32] = 32'h55AA_1234;
    @(posedge clk); @(negedge clk);
    chk("race_stb", 32'(dev_stb_o), 32'h10);
    dev_ack_i = 8'h10; m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("race_ack", 32'(m_ack_o), 32'd1);
    chk("race_dat", m_dat_o, 32'h55AA_1234);
    dev_ack_i = '0;
    @(posedge clk); @(negedge clk);
    chk("race_release", 32'(m_ack_o), 32'd0);

    // Reset in the middle of an access clears outputs without a clock edge.
    @(negedge clk);
    m_adr_i = 32'hFD06_0000; m_we_i = 1'b1; m_dat_i = 32'hDEAD_0006; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_cyc", 32'(dev_cyc_o), 32'h40);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(dev_cyc_o | dev_stb_o), 32'd0);
    chk("mid_rst_ack", 32'(m_ack_o), 32'd0);
    chk("mid_rst_bus", dev_adr_o | dev_dat_o, 32'd0);
    chk("mid_rst_err", err_adr_o | {31'd0, err_tmo_o}, 32'd0);
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_ni = 1'b1;
    run_txn(32'hFD01_0004, 1'b0, 4'hF, 32'h0, 0, 32'h1234_5678, 1'b0, 0, 2, 32'h1234_5678, 1'b0, 1'b0);

    for (int r = 0; r < 60; r++) begin
      int k, hold;
      logic we;
      logic [3:0] sel;
      logic [31:0] wdat, rdat;
      logic [3:0] slot;
      bit noise;
      slot  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      adr   = {8'hFD, 4'h0, slot, 16'($urandom)};
      we    = 1'($urandom);
      sel   = 4'($urandom);
      wdat  = $urandom;
      rdat  = $urandom;
      k     = $urandom_range(0, TIMEOUT + 2);
      noise = 1'($urandom);
      hold  = $urandom_range(0, 2);
      ref_model(adr, we, k, rdat, lat, dat, err, tmo);
      run_txn(adr, we, sel, wdat, k, rdat, noise, hold, lat, dat, err, tmo);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_device_decoder.md
# io_device_decoder

Registered device-select stage downstream of the I/O bridge. Consumes the bridge's single classic-bus master port, decodes the 64 KiB device window from address bits, and drives a one-hot cyc/stb to one of NDEV peripherals over a shared request bus. Returns registered ack and read data. Converts unmapped accesses and non-responding devices into a terminating ack with all-ones data plus a bus-error report, so the bridge never hangs.

## Interface
- NDEV, 8: number of device slots, 1..16. Slot k decodes on adr[19:16]==k.
- TIMEOUT, 255: ACCESS cycles without dev ack before forced termination, >=1.
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- m_cyc_i  in  1  bus cycle from bridge.
- m_stb_i  in  1  strobe from bridge.
- m_ack_o  out  1  registered acknowledge to bridge.
- m_we_i  in  1  write enable.
- m_sel_i  in  4  byte selects.
- m_adr_i  in  32  address (bridge pre-filters to FDxxxxxx).
- m_dat_i  in  32  write data.
- m_dat_o  out  32  registered read data.
- dev_cyc_o  out  NDEV  one-hot cycle per slot.
- dev_stb_o  out  NDEV  one-hot strobe per slot.
- dev_ack_i  in  NDEV  per-slot acknowledge.
- dev_we_o, dev_sel_o, dev_adr_o, dev_dat_o  out  1/4/32/32  shared registered request bus.
- dev_dat_i  in  32*NDEV  read data, slot k in bits [32k+31:32k].
- err_o  out  1  one-cycle pulse on error termination.
- err_adr_o  out  32  address of most recent error.
- err_tmo_o  out  1  cause of most recent error: 1 timeout, 0 unmapped.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: on m_cyc_i & m_stb_i & !m_ack_o, latch we/sel/adr/dat onto dev_* bus; slot = adr[19:16].
  - Mapped (slot < NDEV and slot != 2): dev_cyc_o/dev_stb_o bit slot <= 1; counter <= 0; -> ACCESS.
  - Unmapped (slot >= NDEV or slot == 2, the FTA window): m_dat_o <= FFFFFFFF, m_ack_o <= 1, err_o <= 1, err_adr_o <= adr, err_tmo_o <= 0; -> RESP.
- ACCESS, priority order:
  - dev_ack_i[slot]: m_dat_o <= we ? 0 : dev_dat_i[slot]; clear dev_cyc/stb; m_ack_o <= 1; -> RESP.
  - Else !m_cyc_i: abort; clear dev_cyc/stb; -> IDLE with no ack.
  - Else counter == TIMEOUT: clear dev_cyc/stb; m_dat_o <= FFFFFFFF; m_ack_o <= 1; err_o <= 1; err_adr_o <= dev_adr_o; err_tmo_o <= 1; -> RESP.
  - Else counter++.
- Acks on non-selected slots are ignored.
- RESP: hold m_ack_o and m_dat_o until !m_stb_i or !m_cyc_i. Then m_ack_o <= 0, m_dat_o <= 0; -> IDLE.
- dev_adr/we/sel/dat hold their latched values until the next request is latched. dev_cyc/stb are the only qualifiers.
- Counter width is $clog2(TIMEOUT+1). No wrap, because it stops at TIMEOUT.
- err_o is low in every cycle except the error-termination edge.

## Timing
- Reset (async assert, sync release) clears the following:
  - State = IDLE.
  - m_ack_o = 0, m_dat_o = 0.
  - dev_cyc_o = 0, dev_stb_o = 0, dev_we_o = 0, dev_sel_o = 0, dev_adr_o = 0, dev_dat_o = 0.
  - err_o = 0, err_adr_o = 0, err_tmo_o = 0, counter = 0.
- Reset mid-access drops dev_cyc/stb immediately and issues no ack.
- Mapped latency: request sampled at edge n; dev_stb visible in cycle n+1; dev ack sampled at edge m >= n+1; m_ack_o high after edge m. Minimum is 2 edges from m_stb_i.
- Unmapped latency: m_ack_o high after 1 edge.
- Timeout: m_ack_o high after edge n+1+TIMEOUT when no ack arrives.
- Ack release: m_ack_o falls one edge after stb/cyc is sampled low. The earliest next request is accepted on the following IDLE edge, which matches the bridge waiting for !ack.
- A dev ack arriving on the same edge as cyc dropping is treated as an ack: go to RESP, then release next edge.

## Test plan
- Read slot 1 (adr FD010004), device acks in its first stb cycle with 12345678 -> m_ack_o 2 edges after stb, m_dat_o=12345678, dev_cyc_o=00000010 for exactly 1 cycle, err_o never high.
- Write slot 5 (FD050000, dat A5A5A5A5, sel F) -> dev_adr_o=FD050000, dev_dat_o=A5A5A5A5, dev_we_o=1; on device ack, m_ack_o=1 with m_dat_o=0; m_ack_o drops 1 edge after stb low.
- Unmapped FD0A0000 with NDEV=8, and separately FD020000 -> m_ack_o after 1 edge, m_dat_o=FFFFFFFF, err_o 1-cycle pulse, err_adr_o=address, err_tmo_o=0, dev_cyc_o stays 0.
- TIMEOUT=4, slot 3 never acks -> m_ack_o exactly 6 edges after request sample (1 + 4 + 1); m_dat_o=FFFFFFFF; err_tmo_o=1; err_adr_o=FD03xxxx; dev_cyc_o cleared on the same edge.
- Abort: slot 0 request, m_cyc_i dropped after 2 ACCESS cycles with no ack -> dev_cyc_o cleared next edge, m_ack_o never asserts, next request accepted normally.
- Reset asserted during ACCESS -> all outputs zero immediately, with no clock edge required; after release, a slot-1 read completes normally.
